// File: rtl/mdu_hilo.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// MULT/MULTU/DIV/DIVU take 33 busy cycles; MTHI/MTLO write in one cycle.
module mdu_hilo (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] orig_q, orig_d;
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        signed_op, a_neg, b_neg;
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic [33:0] rem_diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    orig_d   = orig_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    signed_op = (op_i == OP_MULT) || (op_i == OP_DIV);
    a_neg     = signed_op & a_i[31];
    b_neg     = signed_op & b_i[31];

    // Multiply: product accumulates in acc_q, shifted right one bit per step.
    mul_sum  = {1'b0, acc_q[63:32]} + (opb_q[0] ? {1'b0, opa_q} : 33'd0);
    // Divide: partial remainder lives in acc_q[31:0]; quotient shifts into opa_q.
    rem_sh   = {acc_q[31:0], opa_q[31]};
    rem_diff = {1'b0, rem_sh} - {2'b00, opb_q};

    prod_fix = neg_q  ? (64'd0 - acc_q)        : acc_q;
    quo_fix  = neg_q  ? (32'd0 - opa_q)        : opa_q;
    rem_fix  = rneg_q ? (32'd0 - acc_q[31:0])  : acc_q[31:0];

    case (state_q)
      IDLE: begin
        if (start_i) begin
          case (op_i)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              opa_d    = a_neg ? (32'd0 - a_i) : a_i;
              opb_d    = b_neg ? (32'd0 - b_i) : b_i;
              orig_d   = a_i;
              is_div_d = op_i[1];
              neg_d    = a_neg ^ b_neg;
              rneg_d   = a_neg;
              acc_d    = 64'd0;
              cnt_d    = 5'd0;
              state_d  = RUN;
            end
            OP_MTHI: hi_d = a_i;
            OP_MTLO: lo_d = a_i;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (is_div_q) begin
          if (!rem_diff[33]) begin
            acc_d = {32'd0, rem_diff[31:0]};
            opa_d = {opa_q[30:0], 1'b1};
          end else begin
            acc_d = {32'd0, rem_sh[31:0]};
            opa_d = {opa_q[30:0], 1'b0};
          end
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
          opb_d = {1'b0, opb_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          // Divisor is untouched during a divide, so a zero here means divide-by-zero.
          if (opb_q == 32'd0) begin
            hi_d = orig_q;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      opa_q    <= 32'd0;
      opb_q    <= 32'd0;
      orig_q   <= 32'd0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      orig_q   <= orig_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: expected HI/LO queued at start, checked on done_o.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  mdu_hilo dut (
    .clk    (clk),
    .rst    (rst),
    .start_i(start_i),
    .op_i   (op_i),
    .a_i    (a_i),
    .b_i    (b_i),
    .busy_o (busy_o),
    .done_o (done_o),
    .hi_o   (hi_o),
    .lo_o   (lo_o)
  );

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Independent reference for random operations.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   r;
    longint x, y;
    logic [63:0] p;
    int     sa, sd;
    r.hi = 32'd0;
    r.lo = 32'd0;
    case (op)
      3'd0: begin
        x = longint'($signed(a));
        y = longint'($signed(b));
        p = 64'(x * y);
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      3'd1: begin
        p = {32'd0, a} * {32'd0, b};
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          r.hi = a;
          r.lo = 32'hFFFF_FFFF;
        end else if (op == 3'd3) begin
          r.lo = a / b;
          r.hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r.lo = 32'h8000_0000;
          r.hi = 32'd0;
        end else begin
          sa = a;
          sd = b;
          r.lo = 32'(sa / sd);
          r.hi = 32'(sa % sd);
        end
      end
    endcase
    return r;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (done_o === 1'b1) begin
      chk_val("done_has_expect", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk_val("hi", hi_o, e.hi);
        chk_val("lo", lo_o, e.lo);
      end
    end
  end

  // Count busy cycles from the sampling edge; pre = negedges already elapsed.
  task automatic wait_done(input int pre, input string tag);
    int          cyc;
    bit          moved;
    logic [31:0] h0, l0;
    cyc   = pre;
    moved = 1'b0;
    h0    = hi_o;
    l0    = lo_o;
    @(negedge clk);
    while (busy_o === 1'b1 && cyc < 60) begin
      cyc++;
      if (hi_o !== h0 || lo_o !== l0) moved = 1'b1;
      @(negedge clk);
    end
    chk_val({tag, "_busy_cycles"}, cyc, 33);
    chk_val({tag, "_done"}, done_o, 1);
    chk_val({tag, "_hilo_hold"}, moved, 0);
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic arith(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input string tag);
    sb_q.push_back('{hi: eh, lo: el});
    op_i    = op;
    a_i     = a;
    b_i     = b;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    a_i     = $urandom;
    b_i     = $urandom;
    wait_done(0, tag);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    rst = 1'b1; start_i = 1'b0; op_i = 3'd0; a_i = 32'd0; b_i = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_val("rst_hi", hi_o, 0);
    chk_val("rst_lo", lo_o, 0);
    chk_val("rst_busy", busy_o, 0);
    chk_val("rst_done", done_o, 0);

    arith(3'd0, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_m3x5");
    arith(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    arith(3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minsq");
    arith(3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
    arith(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf");
    arith(3'd3, 32'd100,       32'd7,        32'd2,         32'd14,        "divu_100_7");
    arith(3'd3, 32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF, "divu_by0");
    arith(3'd2, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_by0");

    // MTHI then MTLO on consecutive cycles.
    op_i = 3'd4; a_i = 32'hA5A5_A5A5; start_i = 1'b1;
    @(posedge clk);
    #1 op_i = 3'd5; a_i = 32'h5A5A_5A5A;
    @(negedge clk);
    chk_val("mthi_hi", hi_o, 32'hA5A5_A5A5);
    chk_val("mthi_lo_kept", lo_o, 32'hFFFF_FFFF);
    chk_val("mthi_busy", busy_o, 0);
    chk_val("mthi_done", done_o, 0);
    @(posedge clk);
    #1 start_i = 1'b0;
    @(negedge clk);
    chk_val("mtlo_lo", lo_o, 32'h5A5A_5A5A);
    chk_val("mtlo_hi_kept", hi_o, 32'hA5A5_A5A5);
    chk_val("mtlo_busy", busy_o, 0);
    chk_val("mtlo_done", done_o, 0);

    op_i = 3'd6; a_i = 32'h1234_0000; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    @(negedge clk);
    chk_val("nop_hi", hi_o, 32'hA5A5_A5A5);
    chk_val("nop_lo", lo_o, 32'h5A5A_5A5A);
    chk_val("nop_busy", busy_o, 0);

    // MTLO held high while a MULT is in flight must be ignored.
    sb_q.push_back('{hi: 32'd0, lo: 32'd63});
    op_i = 3'd0; a_i = 32'd7; b_i = 32'd9; start_i = 1'b1;
    @(posedge clk);
    #1 op_i = 3'd5; a_i = 32'd0;
    repeat (3) @(posedge clk);
    #1 start_i = 1'b0;
    chk_val("mtlo_while_busy", lo_o, 32'h5A5A_5A5A);
    wait_done(3, "mult_mtlo_busy");

    for (int i = 0; i < 6; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom >> $urandom_range(0, 31);
      e   = model(rop, ra, rb);
      arith(rop, ra, rb, e.hi, e.lo, "rnd");
    end

    // Reset in the middle of a DIVU.
    op_i = 3'd3; a_i = 32'd1000; b_i = 32'd3; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_val("midrst_busy", busy_o, 0);
    chk_val("midrst_done", done_o, 0);
    chk_val("midrst_hi", hi_o, 0);
    chk_val("midrst_lo", lo_o, 0);
    rst = 1'b0;
    @(negedge clk);
    arith(3'd1, 32'd3, 32'd4, 32'd0, 32'd12, "multu_after_rst");

    @(negedge clk);
    chk_val("sb_drain", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
